// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux feeder: channel count, select width,
// output FSM states and the rotating-priority pick function.
package mux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fsm_e;

    // Search starts just after ptr and wraps, so the last winner is tried last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0]  req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way rotating-priority arbiter; ptr remembers the last winner so it
// becomes lowest priority on the next decision.
module rr_arbiter4
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             load,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        win   = rr_pick(req, ptr_q);
        gnt   = '0;
        ptr_d = ptr_q;
        if (load) begin
            gnt[win] = 1'b1;
            ptr_d    = win;
        end
    end

    // ptr resets to the last channel so channel 0 wins the first decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SEL_W'(N_CH - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mux_rr_feeder.sv
// Round-robin scheduler feeding a 4:1 mux: arbitrates four channels and holds
// the selected word in a one-entry valid/ready output register.
module mux_rr_feeder
    import mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    fsm_e                        state_q, state_d;
    logic [WIDTH-1:0]            out_q, out_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic                        load;
    logic [SEL_W-1:0]            win;
    logic [N_CH-1:0][WIDTH-1:0]  ch_data;

    // rst_n gating keeps gnt low while reset is held, even with requests present.
    assign load    = rst_n && (state_q == EMPTY || out_ready) && (|req);
    assign ch_data = {d, c, b, a};

    rr_arbiter4 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .load  (load),
        .gnt   (gnt),
        .win   (win)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sel_d   = sel_q;
        if (load) begin
            state_d = FULL;
            out_d   = ch_data[win];
            sel_d   = win;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
        end
    end

    assign out       = out_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Directed checks of the round-robin mux feeder: rotation, single requester,
// back-pressure, drain, alternation and asynchronous reset.
module tb_mux_rr_feeder;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] out;
    logic       out_valid;
    logic       out_ready;

    int checks;
    int errors;

    mux_rr_feeder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 4'b0; out_ready = 1'b0;
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        req = 4'b1111;
        out_ready = 1'b0;
        #1;
        checks++;
        if ({out, sel, out_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%0d sel=%0d valid=%0b, required 0/0/0", out, sel, out_valid);
        end
        // EMPTY with requests: ptr=3 means channel 0 must be offered first
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_gnt: gnt=%b, required 0001", gnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5];
        logic [3:0] exp_o [5];
        logic [1:0] exp_s [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_o = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (gnt !== exp_g[k]) begin
                errors++;
                $display("FAIL rotation_gnt[%0d]: gnt=%b, required %b", k, gnt, exp_g[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (out !== exp_o[k] || sel !== exp_s[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_out[%0d]: out=%0d sel=%0d valid=%0b, required %0d/%0d/1",
                         k, out, sel, out_valid, exp_o[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_single_requester();
        // continues from rotation: FULL, last winner channel 0
        req = 4'b0100; c = 4'd9; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0100) begin
                errors++;
                $display("FAIL single_gnt[%0d]: gnt=%b, required 0100", k, gnt);
            end
            @(posedge clk); #1;
            checks++;
            if (out !== 4'd9 || sel !== 2'd2 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_out[%0d]: out=%0d sel=%0d valid=%0b, required 9/2/1", k, out, sel, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || out !== 4'd1 || sel !== 2'd0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: gnt=%b out=%0d sel=%0d valid=%0b, required 0000/1/0/1",
                         k, gnt, out, sel, out_valid);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL stall_release_gnt: gnt=%b, required 0010", gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== 4'd2 || sel !== 2'd1) begin
            errors++;
            $display("FAIL stall_release_out: out=%0d sel=%0d, required 2/1", out, sel);
        end
    endtask

    task automatic test_drain();
        apply_reset();
        req = 4'b0001; out_ready = 1'b1;
        @(posedge clk); #1;
        req = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out !== 4'd1 || sel !== 2'd0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL drain_full: valid=%0b out=%0d sel=%0d gnt=%b, required 1/1/0/0000",
                     out_valid, out, sel, gnt);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || sel !== 2'd0 || out !== 4'd1) begin
                errors++;
                $display("FAIL drain_empty[%0d]: valid=%0b sel=%0d out=%0d, required 0/0/1", k, out_valid, sel, out);
            end
        end
    endtask

    task automatic test_alternate();
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b0100; out_ready = 1'b1;
        @(posedge clk); #1;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            #1;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL alternate_gnt[%0d]: gnt=%b, required %b", k, gnt, exp_g);
            end
            @(posedge clk); #1;
            checks++;
            if (out !== ((k % 2 == 0) ? 4'd1 : 4'd3)) begin
                errors++;
                $display("FAIL alternate_out[%0d]: out=%0d, required %0d", k, out, (k % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b1111; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 4'd0 || sel !== 2'd0 || out_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: out=%0d sel=%0d valid=%0b gnt=%b, required 0/0/0/0000",
                     out, sel, out_valid, gnt);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: gnt=%b valid=%0b, required 0000/0", gnt, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_gnt: gnt=%b, required 0001", gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (out !== 4'd1 || sel !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_out: out=%0d sel=%0d valid=%0b, required 1/0/1", out, sel, out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_single_requester();
        test_backpressure();
        test_drain();
        test_alternate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_feeder.md
# mux_rr_feeder

Round-robin source scheduler sitting directly upstream of the 4:1 multiplexer (`mux_4to1`). It arbitrates four requesting channels, generates the 2-bit `sel` that steers the mux, and captures the selected channel's word into a one-entry output register with a valid/ready handshake toward the consumer. Fairness is strict rotation: the channel granted last has lowest priority on the next decision.

## Interface
- `WIDTH`, 4, data width of each channel and of `out`.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  per-channel request; bit i corresponds to channel i (0=a, 1=b, 2=c, 3=d).
- `a`, `b`, `c`, `d`  input  WIDTH  channel data, valid while the matching `req` bit is high.
- `gnt`  output  4  one-hot grant pulse; channel i's word is consumed in the cycle `gnt[i]`=1.
- `sel`  output  2  index of the channel currently held in `out`, driven to the downstream mux.
- `out`  output  WIDTH  registered selected word.
- `out_valid`  output  1  `out` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts `out` this cycle.

## Operation
- Two-state FSM: EMPTY (`out_valid`=0), FULL (`out_valid`=1).
- `load` = (EMPTY or (FULL and `out_ready`)) and |`req`.
- Arbitration is combinational. Search order starts at `ptr`+1 (mod 4) and wraps through the other channels. The first channel whose `req` is set wins.
- When `load` is true:
  - `gnt[win]`=1 for that cycle.
  - On the clock edge: `out` <= channel data, `sel` <= win, `ptr` <= win, `out_valid` <= 1. The FSM enters or stays in FULL.
- When the FSM is FULL, `out_ready`=1 and `req`=0: `out_valid` <= 0 and the FSM returns to EMPTY. `out` and `sel` keep their last values.
- When the FSM is FULL and `out_ready`=0: `gnt`=0. `out`, `sel` and `out_valid` are held stable, and `req` is ignored.
- In EMPTY, `out_ready` has no effect.
- Single requester: that requester is granted on every load opportunity, regardless of `ptr`.
- `gnt` is never asserted for a channel whose `req` is low. `gnt` is all-zero when `load` is false.

## Timing
- Reset values: `out`=0, `sel`=0, `out_valid`=0, `gnt`=0, `ptr`=3 (so channel 0 wins first), FSM=EMPTY.
- Reset is asynchronous: asserting `rst_n` mid-transfer clears all state immediately. An in-flight word is discarded and no `gnt` is issued while reset is active.
- Latency: the cycle in which `req` is granted is followed, at the next edge, by `out_valid`=1 with the data.
- Throughput: 1 word/cycle while `out_ready`=1 and any `req` is present.
- Simultaneous drain and load in FULL produces no bubble: `out_valid` stays 1 and `out`/`sel` are updated.
- `gnt` depends combinationally on `req`, `out_ready` and state. Upstream channels must not derive `req` combinationally from `gnt`.

## Structure
- Shared package `mux_pkg`:
  - `N_CH`=4 and `SEL_W`=2.
  - FSM enum {EMPTY, FULL}.
  - Function `rr_pick(req, ptr)` returning the winner index.
- Sub-module `rr_arbiter4`: rotating-priority search plus the `ptr` register, with `req`, `load` → `gnt`, `win`.
- The top level holds the FSM, the output register and the data mux feeding the output register.

## Test plan
- Hold `req`=4'b1111 with data a=1, b=2, c=3, d=4 and `out_ready`=1. Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001; `out`/`sel` = 1/0, 2/1, 3/2, 4/3, 1/0, one word per cycle.
- Hold `req`=4'b0100 (c=9) with `out_ready`=1. Required: `gnt`=0100 every cycle, `sel`=2, `out`=9 continuously.
- Hold `req`=4'b1111 and drop `out_ready` to 0 for 3 cycles after the first load. Required: `gnt`=0, and `out`=1, `sel`=0, `out_valid`=1 held for those 3 cycles. On release, the next grant is channel 1.
- Pulse `req`=4'b0001 for one cycle, then `req`=0, with `out_ready`=1. Required: `out_valid` is high for exactly one cycle, then returns low with `sel`=0 retained.
- Grant channel 2, then hold `req`=4'b0101. Required: channel 0 is granted next, then channel 2, alternating.
- Assert `rst_n`=0 asynchronously while FULL with `out_ready`=0. Required: outputs clear immediately to reset values. After release, the first grant under `req`=4'b1111 is channel 0.
